sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
Owns the single external 8-bit asynchronous SRAM (20-bit address) and shares it between two requesters: the sampler, which posts 32-bit timestamp words, and the MCU read port, which reads single bytes. The block serialises each word into four byte writes and generates all SRAM control strobes with programmable pulse widths. It replaces the mux-by-sample_end scheme, so sampling and MCU readout can run concurrently without corrupting the bus.

Parameters:
WR_PULSE, 1, number of cycles ram_nwr is held low per byte (1..15)
RD_PULSE, 2, number of cycles ram_nrd is held low per read (1..15)
AW, 20, SRAM address width

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
wr_req  in  1  sampler word-write request, single-cycle qualifier
wr_addr  in  AW  byte address of the word's least significant byte
wr_data  in  32  word to store, little-endian
wr_ready  out  1  one-entry write buffer is empty
wr_ovf  out  1  sticky flag: wr_req arrived while wr_ready was 0
ovf_clr  in  1  clears wr_ovf
rd_req  in  1  MCU byte-read request, single-cycle qualifier
rd_addr  in  AW  read byte address
rd_busy  out  1  read accepted and not yet returned
rd_valid  out  1  one-cycle pulse; rd_data is valid
rd_data  out  8  read byte, held until the next rd_valid
ram_addr  out  AW  SRAM address
ram_nwr  out  1  SRAM write strobe, active-low
ram_nrd  out  1  SRAM read strobe, active-low
ram_dq_out  out  8  data to SRAM
ram_dq_oe  out  1  1 = top level drives ram_dq_out onto the bidirectional pins
ram_dq_in  in  8  data from the SRAM pins

Behaviour:
- Reset (rst=1 at an edge), regardless of state: FSM goes to IDLE. ram_nwr=1, ram_nrd=1, ram_dq_oe=0, ram_addr=0, ram_dq_out=0, wr_ready=1, wr_ovf=0, rd_busy=0, rd_valid=0, rd_data=0. Buffer and pending read are discarded. A transaction cut off mid-way is not completed.
- All outputs are registered.
- Write accept: wr_req=1 and wr_ready=1 at an edge latches wr_addr/wr_data into the buffer, and wr_ready goes to 0.
  - wr_req=1 while wr_ready=0: the request is dropped and wr_ovf is set.
  - ovf_clr clears wr_ovf. If ovf_clr and a new overflow occur in the same cycle, set wins.
- Read accept: rd_req=1 and rd_busy=0 latches rd_addr, and rd_busy goes to 1. rd_req while rd_busy=1 is ignored.
- FSM states: IDLE, W_SETUP, W_PULSE, W_HOLD, R_SETUP, R_PULSE, R_HOLD.
- IDLE arbitration, evaluated on the cycle after accept:
  - Only a buffered write pending: go to W_SETUP, byte index = 0.
  - Only a read pending: go to R_SETUP.
  - Both pending: grant the requester not served last (last_grant register, reset value = read, so a write wins first).
- W_SETUP (1 cycle):
  - ram_addr = buf_addr + byte_idx, computed modulo 2^AW (0xFFFFF+1 wraps to 0x00000).
  - ram_dq_out = buf_data[8*idx+7 : 8*idx], ram_dq_oe = 1, ram_nwr = 1.
- W_PULSE (WR_PULSE cycles): ram_nwr = 0; address and data stable.
- W_HOLD (1 cycle): ram_nwr = 1, data still driven. Then:
  - idx < 3: idx++, return to W_SETUP.
  - idx = 3: ram_dq_oe = 0, wr_ready = 1, last_grant = write, go to IDLE.
- A word is atomic: no read is interleaved between its bytes.
- Word cost: 4*(WR_PULSE+2) cycles.
- R_SETUP (1 cycle): ram_addr = read address, ram_dq_oe = 0, ram_nrd = 1.
- R_PULSE (RD_PULSE cycles): ram_nrd = 0. On the last pulse cycle, ram_dq_in is captured into rd_data.
- R_HOLD (1 cycle): ram_nrd = 1, rd_valid = 1, rd_busy = 0, last_grant = read, go to IDLE.
- Bus safety: ram_dq_oe and ram_nrd=0 are never asserted in the same cycle. ram_nwr and ram_nrd are never both low.
- A new wr_req is accepted in the same cycle wr_ready returns to 1 only if wr_ready was already sampled as 1; there is no combinational bypass.

Decomposition:
- Package sram_arb_pkg holds the state encoding (one-hot, 7 bits), the grant enum {GNT_RD, GNT_WR}, the byte-index width (2), and the pulse-counter width (4).
- One sub-module, sram_wr_buf: one-entry write buffer with wr_ready/wr_ovf/ovf_clr logic.
- The FSM, pulse counter and read capture stay in the top module.

Test Plan:
1. WR_PULSE=1, wr_addr=0x00010, wr_data=0x11223344 -> bytes 0x44@0x00010, 0x33@0x00011, 0x22@0x00012, 0x11@0x00013. Each ram_nwr low for exactly 1 cycle; wr_ready low for 12 FSM cycles plus 1 arbitration cycle.
2. wr_addr=0xFFFFE, data=0xA1B2C3D4 -> writes 0xD4@0xFFFFE, 0xC3@0xFFFFF, 0xB2@0x00000, 0xA1@0x00001.
3. RD_PULSE=2, rd_addr=0x00012 with the model holding 0x22 -> ram_nrd low for 2 cycles, rd_valid one cycle later with rd_data=0x22, rd_busy then 0.
4. wr_req and rd_req in the same cycle after reset -> full 4-byte write first, then the read. Repeat both while a write is in progress -> the read is served before the next write (alternation). Assert the bus-safety invariants throughout.
5. Two wr_req 1 cycle apart -> second dropped, wr_ovf=1. ovf_clr pulse -> wr_ovf=0. ovf_clr together with another overflow -> wr_ovf stays 1.
6. rst asserted during W_PULSE of byte 2 -> next cycle ram_nwr=1, ram_dq_oe=0, wr_ready=1, rd_busy=0, FSM in IDLE, no further SRAM strobes.

Source files
------------

// File: rtl/sram_arb_pkg.sv
// Shared types for the SRAM port arbiter: one-hot FSM encoding, grant enum,
// counter widths and the byte-lane selector used when serialising a word.
package sram_arb_pkg;

    localparam int unsigned STATE_W = 7;
    localparam int unsigned IDX_W   = 2;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned WORD_W  = 32;
    localparam int unsigned BYTE_W  = 8;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 7'b000_0001,
        S_W_SETUP = 7'b000_0010,
        S_W_PULSE = 7'b000_0100,
        S_W_HOLD  = 7'b000_1000,
        S_R_SETUP = 7'b001_0000,
        S_R_PULSE = 7'b010_0000,
        S_R_HOLD  = 7'b100_0000
    } state_t;

    typedef enum logic {
        GNT_RD = 1'b0,
        GNT_WR = 1'b1
    } grant_t;

    // Little-endian byte lane of a word.
    function automatic logic [BYTE_W-1:0] byte_sel(input logic [WORD_W-1:0] word,
                                                   input logic [IDX_W-1:0]  idx);
        return word[{idx, 3'b000} +: BYTE_W];
    endfunction

endpackage

// File: rtl/sram_wr_buf.sv
// One-entry buffer for sampler words, with a sticky overflow flag for
// requests that arrive while the entry is still occupied.
module sram_wr_buf
    import sram_arb_pkg::*;
#(
    parameter int unsigned AW = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_req_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    input  logic              ovf_clr_i,
    input  logic              release_i,
    output logic              wr_ready_o,
    output logic              wr_ovf_o,
    output logic [AW-1:0]     buf_addr_o,
    output logic [WORD_W-1:0] buf_data_o
);

    logic              ready_d, ready_q;
    logic              ovf_d, ovf_q;
    logic [AW-1:0]     addr_d, addr_q;
    logic [WORD_W-1:0] data_d, data_q;

    // Accept only against the registered ready; an overflow beats a clear.
    always_comb begin
        ready_d = ready_q;
        ovf_d   = ovf_q;
        addr_d  = addr_q;
        data_d  = data_q;
        if (release_i) begin
            ready_d = 1'b1;
        end
        if (ovf_clr_i) begin
            ovf_d = 1'b0;
        end
        if (wr_req_i) begin
            if (ready_q) begin
                ready_d = 1'b0;
                addr_d  = wr_addr_i;
                data_d  = wr_data_i;
            end else begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ready_q <= 1'b1;
            ovf_q   <= 1'b0;
            addr_q  <= '0;
            data_q  <= '0;
        end else begin
            ready_q <= ready_d;
            ovf_q   <= ovf_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
        end
    end

    assign wr_ready_o = ready_q;
    assign wr_ovf_o   = ovf_q;
    assign buf_addr_o = addr_q;
    assign buf_data_o = data_q;

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one 8-bit asynchronous SRAM between sampler word writes (split into
// four byte writes) and MCU byte reads, generating all strobes from registers.
module sram_port_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned WR_PULSE = 1,
    parameter int unsigned RD_PULSE = 2,
    parameter int unsigned AW       = 20
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_req_i,
    input  logic [AW-1:0]     wr_addr_i,
    input  logic [WORD_W-1:0] wr_data_i,
    output logic              wr_ready_o,
    output logic              wr_ovf_o,
    input  logic              ovf_clr_i,
    input  logic              rd_req_i,
    input  logic [AW-1:0]     rd_addr_i,
    output logic              rd_busy_o,
    output logic              rd_valid_o,
    output logic [BYTE_W-1:0] rd_data_o,
    output logic [AW-1:0]     ram_addr_o,
    output logic              ram_nwr_o,
    output logic              ram_nrd_o,
    output logic [BYTE_W-1:0] ram_dq_out_o,
    output logic              ram_dq_oe_o,
    input  logic [BYTE_W-1:0] ram_dq_in_i
);

    localparam logic [CNT_W-1:0] WR_LAST  = CNT_W'(WR_PULSE - 1);
    localparam logic [CNT_W-1:0] RD_LAST  = CNT_W'(RD_PULSE - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(3);

    state_t            state_q;
    grant_t            grant_q;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              rd_busy_q;
    logic [AW-1:0]     rd_addr_q;
    logic              rd_valid_q;
    logic [BYTE_W-1:0] rd_data_q;
    logic [AW-1:0]     ram_addr_q;
    logic              ram_nwr_q;
    logic              ram_nrd_q;
    logic [BYTE_W-1:0] ram_dq_out_q;
    logic              ram_dq_oe_q;

    logic              wr_done_c;
    logic              wr_pend_c;
    logic [IDX_W-1:0]  idx_next_c;
    logic [AW-1:0]     buf_addr;
    logic [WORD_W-1:0] buf_data;

    assign wr_done_c  = (state_q == S_W_HOLD) && (idx_q == IDX_LAST);
    assign wr_pend_c  = ~wr_ready_o;
    assign idx_next_c = idx_q + IDX_W'(1);

    sram_wr_buf #(
        .AW(AW)
    ) u_wr_buf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wr_req_i   (wr_req_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .ovf_clr_i  (ovf_clr_i),
        .release_i  (wr_done_c),
        .wr_ready_o (wr_ready_o),
        .wr_ovf_o   (wr_ovf_o),
        .buf_addr_o (buf_addr),
        .buf_data_o (buf_data)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= S_IDLE;
            grant_q      <= GNT_RD;
            idx_q        <= '0;
            cnt_q        <= '0;
            rd_busy_q    <= 1'b0;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
            ram_addr_q   <= '0;
            ram_nwr_q    <= 1'b1;
            ram_nrd_q    <= 1'b1;
            ram_dq_out_q <= '0;
            ram_dq_oe_q  <= 1'b0;
        end else begin
            rd_valid_q <= 1'b0;
            if (rd_req_i && !rd_busy_q) begin
                rd_busy_q <= 1'b1;
                rd_addr_q <= rd_addr_i;
            end
            case (state_q)
                // Round-robin between the two requesters when both wait.
                S_IDLE: begin
                    if (wr_pend_c && (!rd_busy_q || grant_q == GNT_RD)) begin
                        state_q      <= S_W_SETUP;
                        idx_q        <= '0;
                        ram_addr_q   <= buf_addr;
                        ram_dq_out_q <= byte_sel(buf_data, IDX_W'(0));
                        ram_dq_oe_q  <= 1'b1;
                    end else if (rd_busy_q) begin
                        state_q     <= S_R_SETUP;
                        ram_addr_q  <= rd_addr_q;
                        ram_dq_oe_q <= 1'b0;
                    end
                end
                S_W_SETUP: begin
                    state_q   <= S_W_PULSE;
                    ram_nwr_q <= 1'b0;
                    cnt_q     <= '0;
                end
                S_W_PULSE: begin
                    if (cnt_q == WR_LAST) begin
                        state_q   <= S_W_HOLD;
                        ram_nwr_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                // Address wraps modulo 2^AW across the word's bytes.
                S_W_HOLD: begin
                    if (idx_q == IDX_LAST) begin
                        state_q     <= S_IDLE;
                        ram_dq_oe_q <= 1'b0;
                        grant_q     <= GNT_WR;
                    end else begin
                        state_q      <= S_W_SETUP;
                        idx_q        <= idx_next_c;
                        ram_addr_q   <= buf_addr + AW'(idx_next_c);
                        ram_dq_out_q <= byte_sel(buf_data, idx_next_c);
                    end
                end
                S_R_SETUP: begin
                    state_q   <= S_R_PULSE;
                    ram_nrd_q <= 1'b0;
                    cnt_q     <= '0;
                end
                S_R_PULSE: begin
                    if (cnt_q == RD_LAST) begin
                        state_q    <= S_R_HOLD;
                        ram_nrd_q  <= 1'b1;
                        rd_data_q  <= ram_dq_in_i;
                        rd_valid_q <= 1'b1;
                        rd_busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_R_HOLD: begin
                    state_q <= S_IDLE;
                    grant_q <= GNT_RD;
                end
                default: begin
                    state_q     <= S_IDLE;
                    ram_nwr_q   <= 1'b1;
                    ram_nrd_q   <= 1'b1;
                    ram_dq_oe_q <= 1'b0;
                end
            endcase
        end
    end

    assign rd_busy_o    = rd_busy_q;
    assign rd_valid_o   = rd_valid_q;
    assign rd_data_o    = rd_data_q;
    assign ram_addr_o   = ram_addr_q;
    assign ram_nwr_o    = ram_nwr_q;
    assign ram_nrd_o    = ram_nrd_q;
    assign ram_dq_out_o = ram_dq_out_q;
    assign ram_dq_oe_o  = ram_dq_oe_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against a transaction-timing model and a reference memory.
module tb_sram_port_arbiter;

    localparam int unsigned WP = 1;
    localparam int unsigned RP = 2;
    localparam int unsigned AW = 20;
    localparam int BYTE_LEN = int'(WP) + 2;
    localparam int WR_LEN   = 4 * BYTE_LEN;
    localparam int RD_LEN   = int'(RP) + 2;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          wr_req_i;
    logic [AW-1:0] wr_addr_i;
    logic [31:0]   wr_data_i;
    logic          wr_ready_o;
    logic          wr_ovf_o;
    logic          ovf_clr_i;
    logic          rd_req_i;
    logic [AW-1:0] rd_addr_i;
    logic          rd_busy_o;
    logic          rd_valid_o;
    logic [7:0]    rd_data_o;
    logic [AW-1:0] ram_addr_o;
    logic          ram_nwr_o;
    logic          ram_nrd_o;
    logic [7:0]    ram_dq_out_o;
    logic          ram_dq_oe_o;
    logic [7:0]    ram_dq_in_i;

    always #5 clk_i = ~clk_i;

    sram_port_arbiter #(
        .WR_PULSE(WP),
        .RD_PULSE(RP),
        .AW      (AW)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .wr_req_i     (wr_req_i),
        .wr_addr_i    (wr_addr_i),
        .wr_data_i    (wr_data_i),
        .wr_ready_o   (wr_ready_o),
        .wr_ovf_o     (wr_ovf_o),
        .ovf_clr_i    (ovf_clr_i),
        .rd_req_i     (rd_req_i),
        .rd_addr_i    (rd_addr_i),
        .rd_busy_o    (rd_busy_o),
        .rd_valid_o   (rd_valid_o),
        .rd_data_o    (rd_data_o),
        .ram_addr_o   (ram_addr_o),
        .ram_nwr_o    (ram_nwr_o),
        .ram_nrd_o    (ram_nrd_o),
        .ram_dq_out_o (ram_dq_out_o),
        .ram_dq_oe_o  (ram_dq_oe_o),
        .ram_dq_in_i  (ram_dq_in_i)
    );

    // Physical SRAM seen by the DUT, and the memory the model expects.
    logic [7:0] sram    [0:(1<<AW)-1];
    logic [7:0] ref_mem [0:(1<<AW)-1];
    assign ram_dq_in_i = sram[ram_addr_o];

    int n_checks = 0;
    int n_errors = 0;

    bit            m_wpend, m_rpend, m_ovf, m_last_wr, m_job_wr;
    int            m_rem;
    logic [AW-1:0] m_waddr, m_raddr, m_job_addr;
    logic [31:0]   m_wdata, m_job_data;
    logic [7:0]    m_rd_data;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Transaction-level model: a job occupies the bus for a fixed number of
    // cycles, arbitration happens only from idle, and the last-served side yields.
    task automatic model_edge(input bit r, input bit wr, input logic [AW-1:0] wa,
                              input logic [31:0] wd, input bit rd,
                              input logic [AW-1:0] ra, input bit clr);
        bit wp0, rp0;
        if (r) begin
            m_wpend = 0; m_rpend = 0; m_ovf = 0; m_last_wr = 0;
            m_rem = 0; m_rd_data = '0;
        end else begin
            wp0 = m_wpend;
            rp0 = m_rpend;
            if (m_rem == 0) begin
                if (wp0 && (!rp0 || !m_last_wr)) begin
                    m_job_wr = 1; m_rem = WR_LEN; m_job_addr = m_waddr; m_job_data = m_wdata;
                end else if (rp0) begin
                    m_job_wr = 0; m_rem = RD_LEN; m_job_addr = m_raddr;
                end
            end else begin
                m_rem--;
                if (!m_job_wr && m_rem == 1) begin
                    m_rpend   = 0;
                    m_rd_data = ref_mem[m_job_addr];
                end
                if (m_rem == 0) begin
                    m_last_wr = m_job_wr;
                    if (m_job_wr) m_wpend = 0;
                end
            end
            if (wr && !wp0) begin
                m_wpend = 1; m_waddr = wa; m_wdata = wd;
            end
            m_ovf = (wr && wp0) ? 1'b1 : (clr ? 1'b0 : m_ovf);
            if (rd && !rp0) begin
                m_rpend = 1; m_raddr = ra;
            end
        end
    endtask

    task automatic check_outputs();
        bit            e_nwr, e_nrd, e_oe, e_bus;
        logic [AW-1:0] e_addr;
        logic [7:0]    e_dq;
        int            k, b, ph;
        e_nwr = 1; e_nrd = 1; e_oe = 0; e_bus = 0; e_addr = '0; e_dq = '0;
        if (m_rem > 0) begin
            e_bus = 1;
            k = (m_job_wr ? WR_LEN : RD_LEN) - m_rem;
            if (m_job_wr) begin
                b      = k / BYTE_LEN;
                ph     = k % BYTE_LEN;
                e_nwr  = !(ph >= 1 && ph <= int'(WP));
                e_oe   = 1;
                e_addr = m_job_addr + AW'(b);
                e_dq   = m_job_data[8*b +: 8];
                if (!e_nwr) ref_mem[e_addr] = e_dq;
            end else begin
                e_nrd  = !(k >= 1 && k <= int'(RP));
                e_addr = m_job_addr;
            end
        end
        check_eq("wr_ready", 32'(wr_ready_o), 32'(!m_wpend));
        check_eq("wr_ovf", 32'(wr_ovf_o), 32'(m_ovf));
        check_eq("rd_busy", 32'(rd_busy_o), 32'(m_rpend));
        check_eq("rd_valid", 32'(rd_valid_o), 32'(m_rem == 1 && !m_job_wr));
        check_eq("rd_data", 32'(rd_data_o), 32'(m_rd_data));
        check_eq("ram_nwr", 32'(ram_nwr_o), 32'(e_nwr));
        check_eq("ram_nrd", 32'(ram_nrd_o), 32'(e_nrd));
        check_eq("ram_dq_oe", 32'(ram_dq_oe_o), 32'(e_oe));
        if (e_bus) check_eq("ram_addr", 32'(ram_addr_o), 32'(e_addr));
        if (e_oe) check_eq("ram_dq_out", 32'(ram_dq_out_o), 32'(e_dq));
        check_eq("safe_oe_nrd", 32'(ram_dq_oe_o && !ram_nrd_o), 32'(0));
        check_eq("safe_nwr_nrd", 32'(!ram_nwr_o && !ram_nrd_o), 32'(0));
    endtask

    task automatic step(input bit r, input bit wr, input logic [AW-1:0] wa,
                        input logic [31:0] wd, input bit rd,
                        input logic [AW-1:0] ra, input bit clr);
        bit            we;
        logic [AW-1:0] w_a;
        logic [7:0]    w_d;
        rst_i = r; wr_req_i = wr; wr_addr_i = wa; wr_data_i = wd;
        rd_req_i = rd; rd_addr_i = ra; ovf_clr_i = clr;
        we = !ram_nwr_o; w_a = ram_addr_o; w_d = ram_dq_out_o;
        @(posedge clk_i);
        if (we) sram[w_a] = w_d;
        #1;
        model_edge(r, wr, wa, wd, rd, ra, clr);
        check_outputs();
        rst_i = 0; wr_req_i = 0; rd_req_i = 0; ovf_clr_i = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, '0, '0, 0, '0, 0);
    endtask

    task automatic do_reset();
        step(1, 0, '0, '0, 0, '0, 0);
        step(1, 0, '0, '0, 0, '0, 0);
    endtask

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        if ($urandom_range(0, 1) == 0) a = AW'($urandom_range(0, 63));
        else a = AW'(20'hFFFC0) + AW'($urandom_range(0, 63));
        return a;
    endfunction

    initial begin
        int            cnt;
        bit            seen;
        bit            r, wr, rd, clr;
        logic [AW-1:0] wa, ra;
        logic [31:0]   wd;
        logic [AW-1:0] probe;

        for (int i = 0; i < (1 << AW); i++) begin
            sram[i]    = 8'h00;
            ref_mem[i] = 8'h00;
        end
        rst_i = 1; wr_req_i = 0; rd_req_i = 0; ovf_clr_i = 0;
        wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0;
        m_job_wr = 0; m_job_addr = '0; m_job_data = '0;
        m_waddr = '0; m_wdata = '0; m_raddr = '0;

        // Reset state
        do_reset();
        check_eq("rst_ram_addr", 32'(ram_addr_o), 32'h0);
        check_eq("rst_ram_dq_out", 32'(ram_dq_out_o), 32'h0);
        check_eq("rst_wr_ready", 32'(wr_ready_o), 32'h1);

        // Word write, buffer occupancy length
        step(0, 1, 20'h00010, 32'h11223344, 0, '0, 0);
        cnt = 1;
        for (int g = 0; g < 50 && !wr_ready_o; g++) begin
            idle(1);
            if (!wr_ready_o) cnt++;
        end
        check_eq("t1_ready_low", 32'(cnt), 32'(WR_LEN + 1));
        probe = 20'h00010; check_eq("t1_b0", 32'(sram[probe]), 32'h44);
        probe = 20'h00011; check_eq("t1_b1", 32'(sram[probe]), 32'h33);
        probe = 20'h00012; check_eq("t1_b2", 32'(sram[probe]), 32'h22);
        probe = 20'h00013; check_eq("t1_b3", 32'(sram[probe]), 32'h11);

        // Address wrap across the top of memory
        step(0, 1, 20'hFFFFE, 32'hA1B2C3D4, 0, '0, 0);
        idle(WR_LEN + 2);
        probe = 20'hFFFFE; check_eq("t2_b0", 32'(sram[probe]), 32'hD4);
        probe = 20'hFFFFF; check_eq("t2_b1", 32'(sram[probe]), 32'hC3);
        probe = 20'h00000; check_eq("t2_b2", 32'(sram[probe]), 32'hB2);
        probe = 20'h00001; check_eq("t2_b3", 32'(sram[probe]), 32'hA1);

        // Byte read
        step(0, 0, '0, '0, 1, 20'h00012, 0);
        cnt = 0; seen = 0;
        for (int g = 0; g < 20 && !seen; g++) begin
            idle(1);
            if (!ram_nrd_o) cnt++;
            if (rd_valid_o) seen = 1;
        end
        check_eq("t3_valid_seen", 32'(seen), 32'h1);
        check_eq("t3_nrd_width", 32'(cnt), 32'(RP));
        check_eq("t3_rd_data", 32'(rd_data_o), 32'h22);
        idle(2);

        // Simultaneous requests, then alternation
        do_reset();
        step(0, 1, 20'h00020, 32'hCAFEF00D, 1, 20'h00013, 0);
        check_eq("t4_busy", 32'(rd_busy_o), 32'h1);
        for (int g = 0; g < 50 && !wr_ready_o; g++) idle(1);
        step(0, 1, 20'h00024, 32'h0BADBEEF, 1, 20'h00021, 0);
        idle(3);
        step(0, 0, '0, '0, 1, 20'h00022, 0);
        idle(2 * WR_LEN + 2 * RD_LEN);

        // Overflow set / clear / set-wins
        do_reset();
        step(0, 1, 20'h00030, 32'h01020304, 0, '0, 0);
        step(0, 1, 20'h00034, 32'h05060708, 0, '0, 0);
        check_eq("t5_ovf_set", 32'(wr_ovf_o), 32'h1);
        step(0, 0, '0, '0, 0, '0, 1);
        check_eq("t5_ovf_clr", 32'(wr_ovf_o), 32'h0);
        step(0, 1, 20'h00038, 32'h090A0B0C, 0, '0, 1);
        check_eq("t5_ovf_setwins", 32'(wr_ovf_o), 32'h1);
        idle(WR_LEN + 2);

        // Reset during the write pulse of byte 2
        do_reset();
        step(0, 1, 20'h00040, 32'hDEADBEEF, 0, '0, 0);
        seen = 0;
        for (int g = 0; g < 40 && !seen; g++) begin
            idle(1);
            if (m_rem > 0 && m_job_wr && (WR_LEN - m_rem) == 2 * BYTE_LEN + 1) seen = 1;
        end
        check_eq("t6_reached", 32'(seen), 32'h1);
        step(1, 0, '0, '0, 0, '0, 0);
        check_eq("t6_nwr", 32'(ram_nwr_o), 32'h1);
        check_eq("t6_oe", 32'(ram_dq_oe_o), 32'h0);
        check_eq("t6_ready", 32'(wr_ready_o), 32'h1);
        check_eq("t6_busy", 32'(rd_busy_o), 32'h0);
        cnt = 0;
        for (int g = 0; g < 10; g++) begin
            idle(1);
            if (!ram_nwr_o || !ram_nrd_o) cnt++;
        end
        check_eq("t6_no_strobes", 32'(cnt), 32'h0);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            r   = ($urandom_range(0, 399) == 0);
            wr  = ($urandom_range(0, 3) == 0);
            rd  = ($urandom_range(0, 3) == 0);
            clr = ($urandom_range(0, 15) == 0);
            wa  = rand_addr();
            ra  = rand_addr();
            wd  = $urandom();
            step(r, wr, wa, wd, rd, ra, clr);
        end
        idle(WR_LEN + RD_LEN + 4);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
